// File: rtl/io_pkg.sv
// Shared constants and helpers for the memory-mapped input-port bank.
package io_pkg;

  // addr[7:2] value that selects data port 0
  localparam logic [5:0] IO_SEL_BASE = 6'b110000;

  // STATUS sits directly after the last data port
  function automatic logic [5:0] io_status_sel(input int num_ports,
                                               input logic [5:0] base = IO_SEL_BASE);
    return base + 6'(num_ports);
  endfunction

  // MASK sits directly after STATUS
  function automatic logic [5:0] io_mask_sel(input int num_ports,
                                             input logic [5:0] base = IO_SEL_BASE);
    return base + 6'(num_ports + 1);
  endfunction

  // Debounce counter width; never narrower than one bit
  function automatic int io_debounce_cnt_w(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/io_input_debounce.sv
// One input port: synchroniser chain, vector-wide debounce filter and a
// single-cycle change pulse issued on the edge where the stable value updates.
module io_input_debounce import io_pkg::*; #(
  parameter int PORT_W          = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              io_clk,
  input  logic              reset,
  input  logic [PORT_W-1:0] in_port,
  output logic [PORT_W-1:0] stable,
  output logic              chg
);

  localparam int              CNT_W    = io_debounce_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][PORT_W-1:0] sync_q, sync_d;
  logic [PORT_W-1:0]                  stable_q, stable_d;
  logic [PORT_W-1:0]                  sync_out;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic                               chg_d;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Shift the raw input one stage further down the synchroniser chain
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], in_port};
  end

  // Count consecutive cycles of disagreement; adopt the new value on the last one
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    chg_d    = 1'b0;
    if (sync_out == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync_out;
      cnt_d    = '0;
      chg_d    = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers; reset discards any count in progress
  always_ff @(posedge io_clk or posedge reset) begin
    if (reset) begin
      sync_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
  assign chg    = chg_d;

endmodule

// File: rtl/io_input_bank.sv
// Memory-mapped bank of debounced input ports with latched change flags,
// an interrupt mask and a level interrupt on unmasked changes.
module io_input_bank import io_pkg::*; #(
  parameter int         NUM_PORTS       = 4,
  parameter int         PORT_W          = 4,
  parameter logic [5:0] SEL_BASE        = IO_SEL_BASE,
  parameter int         SYNC_STAGES     = 2,
  parameter int         DEBOUNCE_CYCLES = 4
) (
  input  logic                        io_clk,
  input  logic                        reset,
  input  logic [31:0]                 addr,
  input  logic                        io_we,
  input  logic [31:0]                 io_write_data,
  input  logic [NUM_PORTS*PORT_W-1:0] in_port,
  output logic [31:0]                 io_read_data,
  output logic                        irq
);

  localparam logic [5:0] STATUS_SEL = io_status_sel(NUM_PORTS, SEL_BASE);
  localparam logic [5:0] MASK_SEL   = io_mask_sel(NUM_PORTS, SEL_BASE);

  logic [5:0]                         sel;
  logic [NUM_PORTS-1:0][PORT_W-1:0]   stable;
  logic [NUM_PORTS-1:0]               chg;
  logic [NUM_PORTS-1:0]               status_q, status_d;
  logic [NUM_PORTS-1:0]               mask_q, mask_d;
  logic [NUM_PORTS-1:0]               clr;
  logic                               unused_bits;

  assign sel         = addr[7:2];
  assign unused_bits = ^{addr[31:8], addr[1:0], io_write_data[31:NUM_PORTS]};

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    io_input_debounce #(
      .PORT_W         (PORT_W),
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .io_clk (io_clk),
      .reset  (reset),
      .in_port(in_port[g*PORT_W +: PORT_W]),
      .stable (stable[g]),
      .chg    (chg[g])
    );
  end

  // Change flags are write-1-to-clear, a simultaneous change pulse wins; MASK is plain R/W
  always_comb begin
    clr      = '0;
    mask_d   = mask_q;
    if (io_we && (sel == STATUS_SEL)) begin
      clr = io_write_data[NUM_PORTS-1:0];
    end
    if (io_we && (sel == MASK_SEL)) begin
      mask_d = io_write_data[NUM_PORTS-1:0];
    end
    status_d = (status_q & ~clr) | chg;
  end

  // STATUS and MASK registers
  always_ff @(posedge io_clk or posedge reset) begin
    if (reset) begin
      status_q <= '0;
      mask_q   <= '0;
    end else begin
      status_q <= status_d;
      mask_q   <= mask_d;
    end
  end

  assign irq = |(status_q & mask_q);

  // Side-effect-free read mux; unmapped selects read as zero
  always_comb begin
    io_read_data = 32'h0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (sel == SEL_BASE + 6'(i)) begin
        io_read_data = 32'(stable[i]);
      end
    end
    if (sel == STATUS_SEL) begin
      io_read_data = 32'(status_q);
    end
    if (sel == MASK_SEL) begin
      io_read_data = 32'(mask_q);
    end
  end

endmodule
